// File: rtl/test_job_sequencer_pkg.sv
// Shared definitions for the test job sequencer: register maps, CTRL bit
// positions, FSM state encoding and the queued job record.
package test_job_sequencer_pkg;

   localparam logic [1:0] S_ADDR_CTRL  = 2'd0;
   localparam logic [1:0] S_ADDR_JOB   = 2'd1;
   localparam logic [1:0] S_ADDR_LEVEL = 2'd2;
   localparam logic [1:0] S_ADDR_ID    = 2'd3;

   localparam logic [2:0] M_ADDR_GO       = 3'd0;
   localparam logic [2:0] M_ADDR_SET_ADDR = 3'd1;
   localparam logic [2:0] M_ADDR_NUM      = 3'd2;
   localparam logic [2:0] M_ADDR_PLL_LOCK = 3'd3;

   localparam int CTRL_START_BIT     = 0;
   localparam int CTRL_ABORT_BIT     = 1;
   localparam int CTRL_CLEAR_ERR_BIT = 2;

   localparam int STAT_BUSY_BIT        = 0;
   localparam int STAT_ERR_LOCK_BIT    = 1;
   localparam int STAT_ERR_TIMEOUT_BIT = 2;
   localparam int STAT_PUSH_REJ_BIT    = 3;

   localparam logic [31:0] SEQ_ID = 32'h05E0_0001;

   localparam int JOB_W = 23;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_LOCK_RD = 4'd1,
      ST_LOCK_WT = 4'd2,
      ST_WR_ADDR = 4'd3,
      ST_WR_NUM  = 4'd4,
      ST_WR_GO   = 4'd5,
      ST_GAP     = 4'd6,
      ST_POLL_RD = 4'd7,
      ST_POLL_WT = 4'd8,
      ST_KILL    = 4'd9
   } seq_state_e;

   typedef struct packed {
      logic [10:0] start_addr;
      logic [11:0] end_addr;
   } job_t;

   // A job is only meaningful when it covers at least one address.
   function automatic logic job_valid(input job_t job);
      return job.end_addr >= {1'b0, job.start_addr};
   endfunction

endpackage

// File: rtl/test_job_sequencer_job_fifo.sv
// Synchronous job queue with first-word-fall-through read, level output and
// a flush that discards every queued entry in one cycle.
module test_job_sequencer_job_fifo
   import test_job_sequencer_pkg::*;
#(
   parameter int DEPTH = 8
)
(
   input  logic                     avalon_clock,
   input  logic                     resetn,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   input  job_t                     wdata_i,
   output job_t                     rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   job_t             mem_q [DEPTH];
   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             doPush, doPop;

   assign full_o  = (level_q == LVL_W'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign rdata_o = mem_q[rdPtr_q];

   assign doPush = push_i && !full_o;
   assign doPop  = pop_i && !empty_o;

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      level_d = level_q;
      if (doPush) wrPtr_d = wrPtr_q + 1'b1;
      if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
      if (doPush && !doPop) level_d = level_q + 1'b1;
      if (doPop && !doPush) level_d = level_q - 1'b1;
   end

   // Flush wins over a simultaneous push so the queue is guaranteed empty.
   always_ff @(posedge avalon_clock) begin
      if (!resetn || flush_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         level_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         level_q <= level_d;
      end
   end

   always_ff @(posedge avalon_clock) begin
      if (doPush) mem_q[wrPtr_q] <= wdata_i;
   end

endmodule

// File: rtl/test_job_sequencer.sv
// Runs queued adder test jobs on the test control unit: checks PLL lock,
// programs address/count/go over the master port and polls go until done.
module test_job_sequencer
   import test_job_sequencer_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int POLL_GAP = 16,
   parameter int TIMEOUT  = 4096
)
(
   input  logic        avalon_clock,
   input  logic        resetn,
   input  logic [1:0]  s_address,
   input  logic        s_write,
   input  logic        s_read,
   input  logic [31:0] s_writedata,
   output logic [31:0] s_readdata,
   output logic [2:0]  m_address,
   output logic        m_write,
   output logic        m_read,
   output logic [31:0] m_writedata,
   input  logic [31:0] m_readdata,
   output logic        busy
);

   localparam int LVL_W = $clog2(DEPTH) + 1;
   localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(POLL_GAP - 1);
   localparam logic [15:0]      POLL_LIMIT = 16'(TIMEOUT);

   seq_state_e       state_q, state_d;
   logic [GAP_W-1:0] gapCnt_q, gapCnt_d;
   logic [15:0]      pollCnt_q, pollCnt_d;
   logic [15:0]      jobsDone_q, jobsDone_d;
   logic             errLock_q, errLock_d;
   logic             errTimeout_q, errTimeout_d;
   logic             pushRej_q, pushRej_d;
   logic             busy_q, busy_d;
   logic [31:0]      sReadData_q, sReadData_d;
   logic [2:0]       mAddress_q, mAddress_d;
   logic             mWrite_q, mWrite_d;
   logic             mRead_q, mRead_d;
   logic [31:0]      mWriteData_q, mWriteData_d;

   logic             ctrlWr, jobWr, startCmd, abortCmd, clearCmd;
   logic             pushOk, pushRejNow, errAny;
   logic             fifoPop, fifoFlush, fifoFull, fifoEmpty;
   logic [LVL_W-1:0] fifoLevel;
   logic             setErrLock, setErrTimeout, jobDone;
   job_t             newJob, headJob;
   logic             unusedInputs;

   assign unusedInputs = ^{s_writedata[31:28], s_writedata[15:11], m_readdata[31:1]};

   assign ctrlWr   = s_write && (s_address == S_ADDR_CTRL);
   assign jobWr    = s_write && (s_address == S_ADDR_JOB);
   assign startCmd = ctrlWr && s_writedata[CTRL_START_BIT];
   assign abortCmd = ctrlWr && s_writedata[CTRL_ABORT_BIT];
   assign clearCmd = ctrlWr && s_writedata[CTRL_CLEAR_ERR_BIT];

   assign newJob.start_addr = s_writedata[10:0];
   assign newJob.end_addr   = s_writedata[27:16];
   assign pushOk     = jobWr && !fifoFull && job_valid(newJob);
   assign pushRejNow = jobWr && !pushOk;
   assign errAny     = errLock_q || errTimeout_q || pushRej_q;

   test_job_sequencer_job_fifo #(
      .DEPTH (DEPTH)
   ) u_job_fifo (
      .avalon_clock (avalon_clock),
      .resetn       (resetn),
      .push_i       (pushOk),
      .pop_i        (fifoPop),
      .flush_i      (fifoFlush),
      .wdata_i      (newJob),
      .rdata_o      (headJob),
      .full_o       (fifoFull),
      .empty_o      (fifoEmpty),
      .level_o      (fifoLevel)
   );

   // Abort overrides everything outside IDLE/KILL, so a pending read result
   // in LOCK_WT or POLL_WT is simply never looked at.
   always_comb begin
      state_d       = state_q;
      fifoPop       = 1'b0;
      fifoFlush     = 1'b0;
      setErrLock    = 1'b0;
      setErrTimeout = 1'b0;
      jobDone       = 1'b0;
      if (abortCmd && (state_q != ST_IDLE) && (state_q != ST_KILL)) begin
         state_d = ST_KILL;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (abortCmd) fifoFlush = 1'b1;
               else if (startCmd && !fifoEmpty && !errAny) state_d = ST_LOCK_RD;
            end
            ST_LOCK_RD: state_d = ST_LOCK_WT;
            ST_LOCK_WT: begin
               if (!m_readdata[0]) begin
                  setErrLock = 1'b1;
                  state_d    = ST_IDLE;
               end else begin
                  state_d = ST_WR_ADDR;
               end
            end
            ST_WR_ADDR: state_d = ST_WR_NUM;
            ST_WR_NUM:  state_d = ST_WR_GO;
            ST_WR_GO:   state_d = ST_GAP;
            ST_GAP:     if (gapCnt_q == GAP_LAST) state_d = ST_POLL_RD;
            ST_POLL_RD: state_d = ST_POLL_WT;
            ST_POLL_WT: begin
               if (!m_readdata[0]) begin
                  fifoPop = 1'b1;
                  jobDone = 1'b1;
                  state_d = ((fifoLevel > LVL_W'(1)) || pushOk) ? ST_LOCK_RD : ST_IDLE;
               end else if (pollCnt_q >= POLL_LIMIT) begin
                  setErrTimeout = 1'b1;
                  state_d       = ST_KILL;
               end else begin
                  state_d = ST_GAP;
               end
            end
            ST_KILL: begin
               fifoFlush = 1'b1;
               state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Master strobes are decoded from the next state so they are registered
   // yet line up with the cycle the FSM sits in the matching state.
   always_comb begin
      mRead_d      = (state_d == ST_LOCK_RD) || (state_d == ST_POLL_RD);
      mWrite_d     = (state_d == ST_WR_ADDR) || (state_d == ST_WR_NUM) ||
                     (state_d == ST_WR_GO)   || (state_d == ST_KILL);
      mAddress_d   = M_ADDR_GO;
      mWriteData_d = '0;
      case (state_d)
         ST_LOCK_RD: mAddress_d = M_ADDR_PLL_LOCK;
         ST_WR_ADDR: begin
            mAddress_d   = M_ADDR_SET_ADDR;
            mWriteData_d = {21'd0, headJob.start_addr};
         end
         ST_WR_NUM: begin
            mAddress_d   = M_ADDR_NUM;
            mWriteData_d = {20'd0, headJob.end_addr};
         end
         ST_WR_GO: mWriteData_d = 32'd1;
         default: ;
      endcase
   end

   always_comb begin
      gapCnt_d  = (state_q == ST_GAP) ? gapCnt_q + 1'b1 : '0;
      pollCnt_d = pollCnt_q;
      if (state_q == ST_WR_GO)        pollCnt_d = '0;
      else if (state_q == ST_POLL_RD) pollCnt_d = pollCnt_q + 16'd1;
      jobsDone_d   = jobsDone_q + {15'd0, jobDone};
      errLock_d    = (errLock_q    && !clearCmd) || setErrLock;
      errTimeout_d = (errTimeout_q && !clearCmd) || setErrTimeout;
      pushRej_d    = (pushRej_q    && !clearCmd) || pushRejNow;
      busy_d       = (state_q != ST_IDLE) || (state_d != ST_IDLE);
   end

   // CPU readback; the last value is held between reads.
   always_comb begin
      sReadData_d = sReadData_q;
      if (s_read) begin
         case (s_address)
            S_ADDR_CTRL:  sReadData_d = {24'd0, state_q, pushRej_q, errTimeout_q, errLock_q, busy_q};
            S_ADDR_LEVEL: sReadData_d = {jobsDone_q, 16'(fifoLevel)};
            S_ADDR_ID:    sReadData_d = SEQ_ID;
            default:      sReadData_d = '0;
         endcase
      end
   end

   always_ff @(posedge avalon_clock) begin
      if (!resetn) begin
         state_q      <= ST_IDLE;
         gapCnt_q     <= '0;
         pollCnt_q    <= '0;
         jobsDone_q   <= '0;
         errLock_q    <= 1'b0;
         errTimeout_q <= 1'b0;
         pushRej_q    <= 1'b0;
         busy_q       <= 1'b0;
         sReadData_q  <= '0;
         mAddress_q   <= '0;
         mWrite_q     <= 1'b0;
         mRead_q      <= 1'b0;
         mWriteData_q <= '0;
      end else begin
         state_q      <= state_d;
         gapCnt_q     <= gapCnt_d;
         pollCnt_q    <= pollCnt_d;
         jobsDone_q   <= jobsDone_d;
         errLock_q    <= errLock_d;
         errTimeout_q <= errTimeout_d;
         pushRej_q    <= pushRej_d;
         busy_q       <= busy_d;
         sReadData_q  <= sReadData_d;
         mAddress_q   <= mAddress_d;
         mWrite_q     <= mWrite_d;
         mRead_q      <= mRead_d;
         mWriteData_q <= mWriteData_d;
      end
   end

   assign s_readdata  = sReadData_q;
   assign m_address   = mAddress_q;
   assign m_write     = mWrite_q;
   assign m_read      = mRead_q;
   assign m_writedata = mWriteData_q;
   assign busy        = busy_q;

endmodule
